// File: rtl/lut_interp_activation_pipe.sv
// rtl/lut_interp_activation_pipe.sv - banked LUT activation with linear interpolation, 3-stage stallable pipeline
module lut_interp_activation_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int BANKS  = 2,
    localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] z_value,
    input  logic [BSEL_W-1:0]        in_bank,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] a,
    input  logic                     cfg_we,
    input  logic [BSEL_W-1:0]        cfg_bank,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data
);

    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam logic [BSEL_W:0] BANKS_LIM = (BSEL_W + 1)'(BANKS);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (DATA_W - 1)));

    logic signed [DATA_W-1:0] lut [BANKS][DEPTH];

    logic [ADDR_W-1:0]        rd_addr;
    logic [FRAC_W-1:0]        rd_rem;
    logic                     in_bank_ok;
    logic                     cfg_bank_ok;
    logic signed [DATA_W-1:0] rd_base;
    logic signed [DATA_W-1:0] rd_next;

    logic                     stall;
    logic                     accept;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_base;
    logic signed [DATA_W-1:0] s1_next;
    logic [FRAC_W-1:0]        s1_rem;
    logic                     s2_valid;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [PROD_W-1:0] s2_prod;

    logic signed [DATA_W:0]   delta;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [PROD_W-1:0] sum;
    logic signed [DATA_W-1:0] sat;

    assign rd_addr     = z_value[DATA_W-1:FRAC_W];
    assign rd_rem      = z_value[FRAC_W-1:0];
    assign in_bank_ok  = ({1'b0, in_bank} < BANKS_LIM);
    assign cfg_bank_ok = ({1'b0, cfg_bank} < BANKS_LIM);

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Top entry interpolates against itself instead of wrapping to entry 0.
    always_comb begin
        rd_base = '0;
        rd_next = '0;
        if (in_bank_ok) begin
            rd_base = lut[in_bank][rd_addr];
            rd_next = (rd_addr == {ADDR_W{1'b1}}) ? rd_base : lut[in_bank][rd_addr + 1'b1];
        end
    end

    always_comb begin
        delta   = {s1_next[DATA_W-1], s1_next} - {s1_base[DATA_W-1], s1_base};
        prod    = PROD_W'(delta) * $signed(PROD_W'({1'b0, s1_rem}));
        shifted = s2_prod >>> FRAC_W;
        sum     = shifted + PROD_W'(s2_base);
        sat     = sum[DATA_W-1:0];
        if (sum > SAT_MAX) begin
            sat = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            sat = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    // Table writes land at the edge, so a read in the same cycle sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    lut[b][i] <= '0;
                end
            end
        end else if (cfg_we && cfg_bank_ok) begin
            lut[cfg_bank][cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_base   <= '0;
            s1_next   <= '0;
            s1_rem    <= '0;
            s2_valid  <= 1'b0;
            s2_base   <= '0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            a         <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_base <= rd_base;
                s1_next <= rd_next;
                s1_rem  <= rd_rem;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_base <= s1_base;
                s2_prod <= prod;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                a <= sat;
            end
        end
    end

endmodule

// File: tb/tb_lut_interp_activation_pipe.sv
// tb/tb_lut_interp_activation_pipe.sv - randomized bench with behavioural activation model for lut_interp_activation_pipe
module tb_lut_interp_activation_pipe;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        z_value;
    logic [0:0]        in_bank;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] a;
    logic              cfg_we;
    logic [0:0]        cfg_bank;
    logic [3:0]        cfg_addr;
    logic signed [7:0] cfg_data;

    int total = 0;
    int bad   = 0;
    int mlut [2][16];
    int exp_q [$];
    int a_prev = 0;

    lut_interp_activation_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_value   (z_value),
        .in_bank   (in_bank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .cfg_we    (cfg_we),
        .cfg_bank  (cfg_bank),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Activation from the table contents: base + floor(slope * fraction / 16), clamped at the top entry.
    function automatic int model(input int z, input int bank);
        int idx, frac, lo, hi, num, q, r;
        idx  = (z >> 4) & 15;
        frac = z & 15;
        lo   = mlut[bank][idx];
        hi   = (idx == 15) ? lo : mlut[bank][idx + 1];
        num  = (hi - lo) * frac;
        q    = num / 16;
        if (num < 0 && (num % 16) != 0) q = q - 1;
        r = lo + q;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++) mlut[b][i] = 0;
            check("rst_out_valid", int'(out_valid), 0);
        end else begin
            check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (!out_valid) check("a_hold", int'(a), a_prev);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("a_value", int'(a), exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(int'(z_value), int'(in_bank)));
            if (cfg_we) mlut[cfg_bank][cfg_addr] = int'(cfg_data);
        end
        a_prev = int'(a);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int bank, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_bank = 1'(bank);
        cfg_addr = 4'(addr);
        cfg_data = 8'(data);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic one_shot(input string name, input int z, input int bank, input int exp);
        in_valid = 1'b1;
        z_value  = 8'(z);
        in_bank  = 1'(bank);
        step();
        in_valid = 1'b0;
        step();
        check({name, "_early"}, int'(out_valid), 0);
        step();
        check({name, "_valid"}, int'(out_valid), 1);
        check(name, int'(a), exp);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int zs [8];
        int sent, first_ov, low_cnt;
        logic rdy;

        rst = 1'b1; in_valid = 1'b0; z_value = '0; in_bank = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0; cfg_data = '0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_a", int'(a), 0);
        check("reset_in_ready", int'(in_ready), 1);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'sd99;
        in_valid = 1'b1;
        step(); step();
        cfg_we = 1'b0; in_valid = 1'b0;
        rst = 1'b0;
        step(); step();
        one_shot("ignored_cfg_in_rst", 8'h08, 0, 0);

        cfg(0, 3, 20); cfg(0, 4, 36); cfg(0, 5, 40); cfg(0, 6, 10);
        cfg(1, 15, -100); cfg(1, 0, 50);
        one_shot("interp_3a", 8'h3A, 0, 30);
        one_shot("interp_58", 8'h58, 0, 25);
        one_shot("interp_53_floor", 8'h53, 0, 34);
        one_shot("clamp_f7", 8'hF7, 1, -100);

        // Write and read of the same entry in one cycle.
        cfg_we = 1'b1; cfg_bank = 1'b0; cfg_addr = 4'd3; cfg_data = 8'sd0;
        in_valid = 1'b1; z_value = 8'h30; in_bank = 1'b0;
        step();
        cfg_we = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check("same_cycle_old", int'(a), 20);
        step();
        check("after_write_new", int'(a), 0);
        drain();

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) cfg(b, i, int'($urandom_range(255, 0)) - 128);

        foreach (zs[i]) zs[i] = int'($urandom_range(255, 0));
        sent = 0; first_ov = -1; low_cnt = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (first_ov < 0 && out_valid) first_ov = cyc;
            out_ready = !(first_ov >= 0 && cyc - first_ov >= 2 && cyc - first_ov <= 5);
            in_valid  = (sent < 8);
            z_value   = 8'(zs[sent % 8]);
            in_bank   = 1'(sent);
            #1;
            rdy = in_ready;
            if (!rdy) low_cnt++;
            step();
            if (in_valid && rdy) sent++;
        end
        in_valid = 1'b0;
        check("stream_sent", sent, 8);
        check("stream_stall_cycles", low_cnt, 4);
        drain();

        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            z_value   = 8'($urandom);
            in_bank   = 1'($urandom);
            out_ready = ($urandom_range(2, 0) != 0);
            cfg_we    = ($urandom_range(7, 0) == 0);
            cfg_bank  = 1'($urandom);
            cfg_addr  = 4'($urandom);
            cfg_data  = 8'($urandom);
            step();
        end
        cfg_we = 1'b0;
        drain();

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            z_value  = 8'($urandom);
            in_bank  = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("inflight_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_now_out_valid", int'(out_valid), 0);
        check("rst_now_a", int'(a), 0);
        check("rst_now_in_ready", int'(in_ready), 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("no_stale_output", int'(out_valid), 0);
        one_shot("cleared_lut", 8'h3A, 0, 0);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            z_value  = 8'({i[3:0], 4'($urandom)});
            in_bank  = 1'(i >> 4);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_interp_activation_pipe.md
LUT_INTERP_ACTIVATION_PIPE -- requirements
Module: lut_interp_activation_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning signed width of input z and output a.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning LUT index width; FRAC_W = DATA_W-ADDR_W is the interpolation fraction width.
REQ-003 The block SHALL have parameter BANKS, default 2, meaning number of independently programmable activation tables; BSEL_W = max(1,clog2(BANKS)).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1, meaning z_value and in_bank are valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the sample this cycle.
REQ-008 The block SHALL have port z_value, input, DATA_W signed, meaning pre-activation value.
REQ-009 The block SHALL have port in_bank, input, BSEL_W, meaning table used for this sample.
REQ-010 The block SHALL have port out_valid, output, 1, meaning a is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes a this cycle.
REQ-012 The block SHALL have port a, output, DATA_W signed, meaning activation result.
REQ-013 The block SHALL have port cfg_we, input, 1, meaning LUT write strobe.
REQ-014 The block SHALL have ports cfg_bank (BSEL_W), cfg_addr (ADDR_W) and cfg_data (DATA_W signed), all inputs, meaning LUT write target and value.

Function
REQ-015 Per sample: address = z_value[DATA_W-1:FRAC_W] as unsigned index; remaining = z_value[FRAC_W-1:0] zero-extended; change = 2^FRAC_W.
REQ-016 base = LUT[bank][address]; next = LUT[bank][address+1], except address = 2^ADDR_W-1 SHALL use next = base (clamp, no wrap to 0).
REQ-017 a = base + floor(((next-base)*remaining) / 2^FRAC_W), computed as an arithmetic right shift of a full-width signed product (no intermediate truncation).
REQ-018 The result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 Pipeline of 3 register stages: S1 registers base/next/remaining; S2 registers signed delta product; S3 registers saturated sum into a.
REQ-020 A sample accepted (in_valid & in_ready) in cycle N SHALL appear on a with out_valid in cycle N+3 absent backpressure; throughput is one sample per cycle.
REQ-021 stall = out_valid & ~out_ready; in_ready = ~stall; during stall all stages and a SHALL hold and no sample may be lost or duplicated.
REQ-022 Bubbles SHALL propagate as per-stage valid bits; out_valid = S3 valid.
REQ-023 Samples SHALL leave in acceptance order.
REQ-024 cfg_we writes cfg_data to LUT[cfg_bank][cfg_addr] at the clock edge, independent of stall; cfg_bank >= BANKS SHALL be ignored.
REQ-025 A sample whose S1 LUT read occurs in the same cycle as a write to the read entry SHALL use the old value; later reads use the new value.
REQ-026 in_bank >= BANKS SHALL read as all-zero entries (a = 0).
REQ-027 a SHALL hold its value while out_valid is low.

Reset
REQ-028 rst asserted SHALL immediately clear all stage valids, out_valid = 0, a = 0, and all LUT entries to 0.
REQ-029 in_ready SHALL be 1 while rst is high and after release; in-flight samples at reset are discarded, not emitted.
REQ-030 cfg_we and in_valid during rst SHALL be ignored.

Verification
REQ-031 Bank0 LUT[3]=20, LUT[4]=36; z=0x3A, bank0 -> a=30 exactly 3 cycles after acceptance.
REQ-032 Bank0 LUT[5]=40, LUT[6]=10; z=0x58 -> a=25; z=0x53 -> a=34 (floor of -5.625 = -6).
REQ-033 Bank1 LUT[15]=-100, LUT[0]=50; z=0xF7, bank1 -> a=-100 (clamp, no wrap).
REQ-034 Stream 8 back-to-back samples, hold out_ready low cycles 2-5 after first out_valid -> in_ready low during stall, all 8 results in order, none duplicated.
REQ-035 Write bank0 LUT[3]=0 in the same cycle a z=0x30 sample is in S1 -> that sample outputs old value 20; next z=0x30 outputs 0.
REQ-036 Assert rst with 3 samples in flight -> out_valid low immediately, no stale outputs after release, all LUT reads return 0.
